// File: rtl/video_pkg.sv
// Shared video stream types and frame geometry for the camera pipeline.
package video_pkg;

  localparam int HRES = 240;
  localparam int VRES = 320;

  typedef struct packed {
    logic [4:0] r;  // [15:11]
    logic [5:0] g;  // [10:5]
    logic [4:0] b;  // [4:0]
  } rgb565_t;

  typedef logic [7:0] hcount_t;
  typedef logic [8:0] vcount_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one read port, two-cycle read
// (registered address, then registered data). Maps onto a block RAM.
module line_ram #(
  parameter int DEPTH  = 240,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_raddr_p1;
  logic [WIDTH-1:0]  r_rdata_p2;

  // Write port plus the two read stages; read-first on a same-address clash.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // stage p1: capture read address
    r_raddr_p1 <= i_raddr;
    // stage p2: registered read data
    r_rdata_p2 <= r_mem[r_raddr_p1];
  end

  assign o_rdata = r_rdata_p2;

endmodule

// File: rtl/line_buffer.sv
// Producer side of the 3x3 window: four rotating line RAMs; for each pixel
// the three previously completed lines at the same column come out two
// cycles later, together with the delayed hcount/vcount/valid.
module line_buffer #(
  parameter int HRES        = video_pkg::HRES,
  parameter int VRES        = video_pkg::VRES,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [PIXEL_WIDTH-1:0]           data_in,
  input  video_pkg::hcount_t               hcount_in,
  input  video_pkg::vcount_t               vcount_in,
  input  logic                             data_valid_in,
  output logic [2:0][PIXEL_WIDTH-1:0]      data_out,
  output video_pkg::hcount_t               hcount_out,
  output video_pkg::vcount_t               vcount_out,
  output logic                             data_valid_out
);

  localparam int AW = $clog2(HRES);

  logic                   w_accept;
  logic                   w_last_col;
  logic [AW-1:0]          w_addr;
  logic [PIXEL_WIDTH-1:0] w_rdata [4];

  logic [1:0]             r_wr_sel;
  logic                   r_vld_p1, r_vld_p2;
  video_pkg::hcount_t     r_hcount_p1, r_hcount_p2;
  video_pkg::vcount_t     r_vcount_p1, r_vcount_p2;
  logic [1:0]             r_sel_p1, r_sel_p2;

  // Writes are suppressed while reset is held so a reset mid-line leaves RAMs untouched.
  assign w_accept   = rst_in && data_valid_in &&
                      (32'(hcount_in) < HRES) && (32'(vcount_in) < VRES);
  assign w_last_col = (32'(hcount_in) == HRES - 1);
  assign w_addr     = hcount_in[AW-1:0];

  // Advance the write RAM after the last column of a line has been stored.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_sel <= 2'd0;
    end else if (w_accept && w_last_col) begin
      r_wr_sel <= r_wr_sel + 2'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ram
    line_ram #(
      .DEPTH (HRES),
      .WIDTH (PIXEL_WIDTH),
      .ADDR_W(AW)
    ) u_ram (
      .clk_in (clk_in),
      .i_we   (w_accept && (r_wr_sel == 2'(g))),
      .i_waddr(w_addr),
      .i_wdata(data_in),
      .i_raddr(w_addr),
      .o_rdata(w_rdata[g])
    );
  end

  // Side-band pipeline matching the RAM read latency; the write select is
  // captured at issue so a rotation never re-steers reads already in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_hcount_p1 <= '0;
      r_hcount_p2 <= '0;
      r_vcount_p1 <= '0;
      r_vcount_p2 <= '0;
      r_sel_p1    <= 2'd0;
      r_sel_p2    <= 2'd0;
    end else begin
      // stage p1: issue
      r_vld_p1    <= w_accept;
      r_hcount_p1 <= hcount_in;
      r_vcount_p1 <= vcount_in;
      r_sel_p1    <= r_wr_sel;
      // stage p2: aligned with RAM data
      r_vld_p2    <= r_vld_p1;
      r_hcount_p2 <= r_hcount_p1;
      r_vcount_p2 <= r_vcount_p1;
      r_sel_p2    <= r_sel_p1;
    end
  end

  // Steer RAM outputs to bottom/mid/top rows; zero when no valid output.
  always_comb begin
    data_out = '0;
    if (r_vld_p2) begin
      data_out[0] = w_rdata[r_sel_p2 - 2'd1];
      data_out[1] = w_rdata[r_sel_p2 - 2'd2];
      data_out[2] = w_rdata[r_sel_p2 - 2'd3];
    end
  end

  assign hcount_out     = r_hcount_p2;
  assign vcount_out     = r_vcount_p2;
  assign data_valid_out = r_vld_p2;

endmodule
